serial_subtractor: RTL and testbench

- Bit-serial unsigned subtractor. Computes d = a - b - bin and a borrow-out, one bit per clock, LSB first.
- Complements the lab's combinational ripple-carry adder: it is the subtract direction, trading area for latency.
- Sits between a producer and a consumer, with a valid/ready handshake on both sides.

---
 rtl/serial_subtractor_pkg.sv | 19 +
 rtl/serial_subtractor_full_subtractor.sv | 21 ++
 rtl/serial_subtractor.sv | 165 ++++++++++++++++
 tb/tb_serial_subtractor.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg
// Shared definitions for the bit-serial subtractor slice.
//   sub_state_t : controller states (IDLE -> RUN -> DONE -> IDLE)
//   DEFAULT_W   : default operand width
//   cnt_width() : width of the bit counter, never less than one bit
// Optional feature macro used by this slice: SERIAL_SUBTRACTOR_OVF_EN

package serial_subtractor_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} sub_state_t;

    localparam int DEFAULT_W = 4;

    // A one-bit operand still needs a one-bit counter, so clamp at 1.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// full_subtractor
// Combinational 1-bit subtractor cell: computes x - y - bi.
// Ports:
//   x  : input  minuend bit
//   y  : input  subtrahend bit
//   bi : input  borrow-in
//   d  : output difference bit
//   bo : output borrow-out

module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = x ^ y ^ bi;
    assign bo = (~x & y) | (~x & bi) | (y & bi);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor
// Bit-serial unsigned subtractor: d = a - b - bin (mod 2^W) and borrow-out,
// one bit per clock, LSB first, with valid/ready handshakes on both sides.
// Parameters:
//   W : operand/result width (W >= 1)
// Ports:
//   clk       : input  system clock, rising edge
//   reset     : input  synchronous active-high reset
//   in_valid  : input  producer offers a, b, bin
//   in_ready  : output block can accept operands (IDLE only)
//   a, b      : input  unsigned minuend / subtrahend
//   bin       : input  borrow-in
//   out_valid : output result valid (DONE only)
//   out_ready : input  consumer accepts result
//   d         : output difference, modulo 2^W
//   bout      : output borrow-out, 1 iff a < b + bin
//   ovf       : output signed overflow (only with SERIAL_SUBTRACTOR_OVF_EN)
// Optional feature macro: SERIAL_SUBTRACTOR_OVF_EN

module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] d,
    output logic         bout
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int CW = cnt_width(W);
    localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

    sub_state_t    state;
    sub_state_t    state_next;
    logic [W-1:0]  a_sh;
    logic [W-1:0]  b_sh;
    logic [W-1:0]  res_sh;
    logic [W-1:0]  res_next;
    logic          borrow;
    logic [CW-1:0] cnt;
    logic          last_bit;
    logic          diff_bit;
    logic          borrow_next;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic          sign_a;
    logic          sign_b;
`endif

    // One cell does all the arithmetic; the shift registers feed it LSB first.
    full_subtractor u_cell (
        .x  (a_sh[0]),
        .y  (b_sh[0]),
        .bi (borrow),
        .d  (diff_bit),
        .bo (borrow_next)
    );

    // The new difference bit enters at the top so that after W shifts the
    // first (LSB) result bit has walked down to bit 0.
    assign res_next = W'({diff_bit, res_sh} >> 1);
    assign last_bit = (cnt == LAST_CNT);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: operands are captured only on acceptance, then shifted one
    // bit per RUN cycle. The visible result registers change only when the
    // last bit completes (or on reset), so they hold through IDLE and RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            d      <= '0;
            bout   <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            ovf    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        borrow <= bin;
                        cnt    <= '0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                        sign_a <= a[W-1];
                        sign_b <= b[W-1];
`endif
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= res_next;
                    borrow <= borrow_next;
                    cnt    <= cnt + CW'(1);
                    if (last_bit) begin
                        d    <= res_next;
                        bout <= borrow_next;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                        ovf  <= (sign_a != sign_b) && (res_next[W-1] != sign_a);
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
// Self-checking bench for serial_subtractor (W = 4). A driver issues
// directed and random operand sets and pushes the reference result into a
// scoreboard queue; a monitor pops and compares whenever the DUT presents
// a result. Optional feature macro: SERIAL_SUBTRACTOR_OVF_EN

module tb_serial_subtractor;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0] d;
        logic         bout;
        logic         ovf;
        int           edge_no;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] d;
    logic         bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic         ovf;
`endif

    int checks = 0;
    int passes = 0;
    int edge_cnt = 0;
    int ready_mode = 0;
    exp_t sb_q[$];
    int rise_q[$];
    logic seen = 1'b0;
    logic [W-1:0] held_d;
    logic held_bout;

    serial_subtractor #(.W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .bout      (bout)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Consumer side: 0 = always ready, 1 = stalled, 2 = random.
    always begin
        @(posedge clk);
        #2;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'b0;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic reportTimeout(input string name);
        checks++;
        $display("[TB] FAIL %s: bound expired, got no event, expected one", name);
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic exp_t model(input int av, input int bv, input int bi);
        exp_t e;
        int diff;
        logic [31:0] bits;
        logic [W-1:0] av_bits;
        logic [W-1:0] bv_bits;
        diff = av - bv - bi;
        bits = diff;
        av_bits = W'(av);
        bv_bits = W'(bv);
        e.d = bits[W-1:0];
        e.bout = (av < bv + bi);
        e.ovf = (av_bits[W-1] != bv_bits[W-1]) && (e.d[W-1] != av_bits[W-1]);
        e.edge_no = 0;
        return e;
    endfunction

    task automatic applyStimulus(input int av, input int bv, input int bi);
        exp_t e;
        bit accepted;
        accepted = 0;
        for (int t = 0; t < 100 && !accepted; t++) begin
            @(posedge clk);
            #1;
            a = W'(av);
            b = W'(bv);
            bin = 1'(bi);
            in_valid = 1'b1;
            if (in_ready) accepted = 1;
        end
        if (!accepted) begin
            reportTimeout("accept");
            in_valid = 1'b0;
        end else begin
            e = model(av, bv, bi);
            e.edge_no = edge_cnt + 1;
            sb_q.push_back(e);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic waitIdle();
        int t;
        t = 0;
        while ((sb_q.size() != 0 || out_valid) && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 300) reportTimeout("drain");
    endtask

    // Scoreboard monitor: compares once when a result appears, then checks
    // that it stays stable until the consumer takes it.
    always @(negedge clk) begin
        if (reset) begin
            sb_q.delete();
            seen = 1'b0;
        end else if (out_valid) begin
            if (!seen) begin
                seen = 1'b1;
                held_d = d;
                held_bout = bout;
                rise_q.push_back(edge_cnt);
                if (sb_q.size() == 0) begin
                    checkOutput("unexpected_result_q", 32'(sb_q.size()), 32'd1);
                end else begin
                    checkOutput("d", 32'(d), 32'(sb_q[0].d));
                    checkOutput("bout", 32'(bout), 32'(sb_q[0].bout));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                    checkOutput("ovf", 32'(ovf), 32'(sb_q[0].ovf));
`endif
                    checkOutput("latency", 32'(edge_cnt - sb_q[0].edge_no), 32'(W));
                end
            end else begin
                checkOutput("d_hold", 32'(d), 32'(held_d));
                checkOutput("bout_hold", 32'(bout), 32'(held_bout));
            end
            if (out_ready) begin
                if (sb_q.size() != 0) void'(sb_q.pop_front());
                seen = 1'b0;
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_d", 32'(d), 32'd0);
        checkOutput("reset_bout", 32'(bout), 32'd0);

        // 9 - 3, with in_ready low through RUN and the DONE cycle.
        applyStimulus(9, 3, 0);
        for (int i = 0; i <= W; i++) begin
            checkOutput("busy_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        checkOutput("idle_in_ready", 32'(in_ready), 32'd1);
        waitIdle();

        applyStimulus(3, 9, 0);
        waitIdle();
        applyStimulus(0, 0, 1);
        waitIdle();

        // Backpressure with ignored operand pulses while DONE is stalled.
        ready_mode = 1;
        applyStimulus(7, 2, 0);
        for (int t = 0; t < 50 && !out_valid; t++) begin
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            a = 1;
            b = 1;
            bin = 0;
            in_valid = 1'b1;
            checkOutput("stall_out_valid", 32'(out_valid), 32'd1);
            checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
            checkOutput("stall_d", 32'(d), 32'd5);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        ready_mode = 0;
        @(posedge clk);
        #1;
        checkOutput("release_in_ready", 32'(in_ready), 32'd1);
        checkOutput("release_out_valid", 32'(out_valid), 32'd0);
        waitIdle();

        // Reset in the second RUN cycle discards the operation.
        applyStimulus(13, 2, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("midrun_in_ready", 32'(in_ready), 32'd1);
        checkOutput("midrun_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrun_d", 32'(d), 32'd0);
        checkOutput("midrun_bout", 32'(bout), 32'd0);
        applyStimulus(4, 1, 0);
        waitIdle();

        // Back-to-back operations: results spaced W+2 cycles apart.
        rise_q.delete();
        applyStimulus(15, 1, 0);
        applyStimulus(1, 15, 0);
        applyStimulus(8, 8, 0);
        waitIdle();
        checkOutput("b2b_count", 32'(rise_q.size()), 32'd3);
        for (int i = 1; i < rise_q.size(); i++) begin
            checkOutput("b2b_spacing", 32'(rise_q[i] - rise_q[i-1]), 32'(W + 2));
        end

`ifdef SERIAL_SUBTRACTOR_OVF_EN
        applyStimulus(8, 1, 0);
        waitIdle();
        applyStimulus(5, 2, 0);
        waitIdle();
`endif

        // Random operands with a randomly stalling consumer.
        ready_mode = 2;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(int'($urandom_range(0, (1 << W) - 1)),
                          int'($urandom_range(0, (1 << W) - 1)),
                          int'($urandom_range(0, 1)));
        end
        waitIdle();
        ready_mode = 0;
        repeat (2) @(posedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
